div_iter: RTL and testbench



---
 rtl/div_iter_if.sv | 20 ++
 rtl/div_iter.sv | 139 +++++++++++++
 tb/tb_div_iter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/div_iter_if.sv
// ALU-to-divider request/response bundle: level request with operands, result valid with Hi/Lo.
interface div_iter_if;
  logic        validIn;
  logic        sign;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        validOut;
  logic [31:0] Hi;
  logic [31:0] Lo;

  modport master (
    output validIn, sign, SrcA, SrcB,
    input  validOut, Hi, Lo
  );

  modport slave (
    input  validIn, sign, SrcA, SrcB,
    output validOut, Hi, Lo
  );
endinterface

// File: rtl/div_iter.sv
// Iterative 32-bit restoring divider (DIV/DIVU): result 34 edges after accept; validIn is a held level, no new work until it drops in DONE.
// DIV_ZERO_FAST_EN: zero divisor short-circuits to DONE one edge after accept.
module div_iter (
  input  logic     clk,
  input  logic     reset,
  div_iter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [5:0]  cnt;
  logic [31:0] a_raw;
  logic [31:0] b_mag;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        accept;
  logic        step_en;
  logic        load_res;
  logic        b_zero;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign accept  = (state == IDLE) && bus.validIn;
  // Steps run for counter 0..31; the counter==32 cycle lets the last partial remainder settle.
  assign step_en = (state == CALC) && !cnt[5];
  assign b_zero  = (b_mag == 32'd0);

  assign a_abs = (bus.sign && bus.SrcA[31]) ? (~bus.SrcA + 32'd1) : bus.SrcA;
  assign b_abs = (bus.sign && bus.SrcB[31]) ? (~bus.SrcB + 32'd1) : bus.SrcB;

  assign rem_sh = {rem, quo[31]};
  assign diff   = rem_sh - {1'b0, b_mag};

  // Zero divisor returns the untouched dividend; overflow case falls out of the negate.
  assign res_lo = b_zero ? 32'hFFFF_FFFF : (neg_q ? (~quo + 32'd1) : quo);
  assign res_hi = b_zero ? a_raw         : (neg_r ? (~rem + 32'd1) : rem);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_res  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.validIn) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
`ifdef DIV_ZERO_FAST_EN
        if ((cnt == 6'd0) && b_zero) begin
          state_nxt = DONE;
          load_res  = 1'b1;
        end else if (cnt == 6'd32) begin
          state_nxt = FIX;
        end
`else
        if (cnt == 6'd32) begin
          state_nxt = FIX;
        end
`endif
      end
      FIX: begin
        state_nxt = DONE;
        load_res  = 1'b1;
      end
      DONE: begin
        if (!bus.validIn) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= 6'd0;
      a_raw <= 32'd0;
      b_mag <= 32'd0;
      quo   <= 32'd0;
      rem   <= 32'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      if (accept) begin
        cnt   <= 6'd0;
        a_raw <= bus.SrcA;
        b_mag <= b_abs;
        quo   <= a_abs;
        rem   <= 32'd0;
        neg_q <= bus.sign & (bus.SrcA[31] ^ bus.SrcB[31]);
        neg_r <= bus.sign & bus.SrcA[31];
      end else if (state == CALC) begin
        cnt <= cnt + 6'd1;
        if (step_en) begin
          quo <= {quo[30:0], ~diff[32]};
          rem <= diff[32] ? rem_sh[31:0] : diff[31:0];
        end
      end
      if (load_res) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  assign bus.validOut = (state == DONE);
  assign bus.Hi       = hi_q;
  assign bus.Lo       = lo_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed-vector bench for div_iter: driver pushes expected results, negedge monitor pops and compares.
module tb_div_iter;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          lat;
  } exp_t;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 34;
`endif
  localparam int NLAT = 34;

  logic clk;
  logic reset;
  div_iter_if bus ();

  div_iter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   vectors;
  int   miscompares;
  int   cyc;
  int   acc_cyc;
  exp_t exp_q[$];
  exp_t cur;
  logic prev_vld;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no end, need summary");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %08h, need %08h", name, act, req);
    end
  endtask

  // Monitor: pops on each rising validOut and checks hold-stability while DONE persists.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.validOut && !prev_vld) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_valid: got validOut=1, need no result pending");
        end else begin
          cur = exp_q.pop_front();
          check32("Lo", bus.Lo, cur.lo);
          check32("Hi", bus.Hi, cur.hi);
          check32("latency", 32'(cyc - acc_cyc), 32'(cur.lat));
        end
      end else if (bus.validOut && prev_vld) begin
        check32("Lo_hold", bus.Lo, cur.lo);
        check32("Hi_hold", bus.Hi, cur.hi);
      end
    end
    prev_vld = bus.validOut;
  end

  task automatic run(input logic s, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] lo, input logic [31:0] hi, input int lat, input int hold);
    exp_t e;
    int   n;
    @(negedge clk);
    bus.validIn = 1'b1;
    bus.sign    = s;
    bus.SrcA    = a;
    bus.SrcB    = b;
    e.lo = lo;
    e.hi = hi;
    e.lat = lat;
    exp_q.push_back(e);
    @(posedge clk);
    #1 acc_cyc = cyc;
    @(negedge clk);
    // Scramble operands after accept; the result must not move.
    bus.SrcA = ~a;
    bus.SrcB = 32'h0000_1234;
    bus.sign = ~s;
    n = 0;
    while (!bus.validOut && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.validOut) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: got no validOut in 100 cycles, need validOut=1");
      exp_q.delete();
    end
    repeat (hold) @(negedge clk);
    bus.validIn = 1'b0;
    @(negedge clk);
    check32("drop_to_idle", {31'd0, bus.validOut}, 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    acc_cyc     = 0;
    prev_vld    = 1'b0;
    reset       = 1'b1;
    bus.validIn = 1'b1;
    bus.sign    = 1'b0;
    bus.SrcA    = 32'd50;
    bus.SrcB    = 32'd5;

    // Reset held with validIn high must not accept.
    repeat (3) @(negedge clk);
    check32("rst_valid", {31'd0, bus.validOut}, 32'd0);
    check32("rst_Hi", bus.Hi, 32'd0);
    check32("rst_Lo", bus.Lo, 32'd0);
    reset       = 1'b0;
    bus.validIn = 1'b0;
    repeat (2) @(negedge clk);

    run(1'b0, 32'd100,        32'd7,        32'h0000_000E, 32'h0000_0002, NLAT, 0);
    run(1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, NLAT, 0);
    run(1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001, NLAT, 0);
    run(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, NLAT, 0);
    run(1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, NLAT, 0);
    run(1'b0, 32'd5,          32'd0,        32'hFFFF_FFFF, 32'h0000_0005, ZLAT, 0);
    run(1'b1, 32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFB, ZLAT, 0);
    run(1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, NLAT, 0);
    run(1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'h0000_000E, 32'hFFFF_FFFE, NLAT, 0);
    run(1'b0, 32'd0,          32'd5,        32'h0000_0000, 32'h0000_0000, NLAT, 0);
    run(1'b0, 32'd1000,       32'd10,       32'h0000_0064, 32'h0000_0000, NLAT, 5);

    // Abort mid-calculation with reset; no result may appear for it.
    @(negedge clk);
    bus.validIn = 1'b1;
    bus.sign    = 1'b0;
    bus.SrcA    = 32'd123;
    bus.SrcB    = 32'd4;
    @(posedge clk);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset       = 1'b0;
    bus.validIn = 1'b0;
    check32("abort_valid", {31'd0, bus.validOut}, 32'd0);
    check32("abort_Hi", bus.Hi, 32'd0);
    check32("abort_Lo", bus.Lo, 32'd0);
    repeat (40) @(negedge clk);

    run(1'b0, 32'd9, 32'd3, 32'h0000_0003, 32'h0000_0000, NLAT, 0);

    repeat (40) @(negedge clk);
    check32("pending_left", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
